counter_modal: RTL

COUNTER_MODAL -- requirements
Module: counter_modal

---
 rtl/counter_modal.sv | 87 ++++++++
 1 files changed

// File: rtl/counter_modal.sv
// Up/down modulo counter with parallel load, selectable wrap or saturate at
// the boundaries, a one-cycle terminal pulse and a sticky wrapped flag.
module counter_modal #(
    parameter int unsigned Size     = 5,
    parameter int unsigned Modulus  = 32,
    parameter int unsigned Saturate = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            up,
    input  logic            load,
    input  logic [Size-1:0] load_value,
    input  logic            clear_wrapped,
    output logic [Size-1:0] count,
    output logic            terminal,
    output logic            wrapped
);

    localparam logic [Size-1:0] MaxVal   = Size'(Modulus - 1);
    // One bit wider so the load compare holds even when Modulus == 2**Size
    localparam logic [Size:0]   ModWide  = (Size + 1)'(Modulus);
    localparam bit              SatMode  = (Saturate != 0);

    logic [Size-1:0] count_q, count_d;
    logic            terminal_q, terminal_d;
    logic            wrapped_q, wrapped_d;
    logic            boundary;

    // Next-state: load beats step; boundary sets wrapped over a clear
    always_comb begin
        count_d    = count_q;
        terminal_d = 1'b0;
        wrapped_d  = wrapped_q;
        boundary   = 1'b0;

        if (clear_wrapped) begin
            wrapped_d = 1'b0;
        end

        if (load) begin
            if ({1'b0, load_value} < ModWide) begin
                count_d = load_value;
            end else begin
                count_d = MaxVal;
            end
        end else if (enable) begin
            if (up) begin
                if (count_q == MaxVal) begin
                    boundary = 1'b1;
                    count_d  = SatMode ? MaxVal : '0;
                end else begin
                    count_d = count_q + Size'(1);
                end
            end else begin
                if (count_q == '0) begin
                    boundary = 1'b1;
                    count_d  = SatMode ? '0 : MaxVal;
                end else begin
                    count_d = count_q - Size'(1);
                end
            end
        end

        if (boundary) begin
            terminal_d = 1'b1;
            wrapped_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q    <= '0;
            terminal_q <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            terminal_q <= terminal_d;
            wrapped_q  <= wrapped_d;
        end
    end

    assign count    = count_q;
    assign terminal = terminal_q;
    assign wrapped  = wrapped_q;

endmodule
